i2c_bus_arbiter: RTL

Master-side transaction sequencer and round-robin arbiter for the byte-parallel I2C bus that feeds the single-byte slave (address byte, ACK, one data byte). Up to NUM_REQ local requesters each post a single-byte read or write. The block grants one requester at a time, snapshots its request and drives the address and data phases on the shared bus byte. It then waits for the active-low slave ACK, captures read data and returns a one-cycle completion pulse with an error flag.

---
 rtl/i2c_bus_arbiter_if.sv | 28 ++
 rtl/i2c_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Requester and slave-bus signal bundle for the I2C transaction arbiter.
// The arbiter takes the master view; the requester/slave side takes the slave view.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;
    logic                 busy;
    logic [7:0]           bus_byte;
    logic                 bus_ack_n;
    logic [7:0]           bus_rdata;

    modport master (
        input  req, req_addr, req_rw, req_wdata, bus_ack_n, bus_rdata,
        output grant, done, err, rdata, busy, bus_byte
    );

    modport slave (
        output req, req_addr, req_rw, req_wdata, bus_ack_n, bus_rdata,
        input  grant, done, err, rdata, busy, bus_byte
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and address/ACK/data sequencer for the byte-parallel I2C slave bus.
// 8 cycles request-to-idle with ACK on first sample; requests are held off (no grant) while busy.
module i2c_bus_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         ACK_TIMEOUT = 4,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic               m_SCL,
    input  logic               m_RSTn,
    i2c_bus_arbiter_if.master  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_ACKW = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;

    // First active requester at or after the round-robin pointer, with wrap.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick_idx;
                    addr_d  = bus.req_addr[7*pick_idx +: 7];
                    rw_d    = bus.req_rw[pick_idx];
                    wdata_d = bus.req_wdata[8*pick_idx +: 8];
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 4'd2) begin
                    cnt_d   = '0;
                    state_d = S_ACKW;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACKW: begin
                if (!bus.bus_ack_n) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else if (cnt_q == 4'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 4'd2) begin
                    if (!rw_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                err_d   = 1'b0;
                ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_SCL) begin
        if (!m_RSTn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    logic [7:0] bus_byte_c;

    always_comb begin
        bus_byte_c = IDLE_BYTE;
        case (state_q)
            S_ADDR, S_ACKW: bus_byte_c = {addr_q, rw_q};
            S_DATA:         bus_byte_c = rw_q ? wdata_q : IDLE_BYTE;
            default:        bus_byte_c = IDLE_BYTE;
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.done     = (state_q == S_DONE) ? grant_q : '0;
    assign bus.err      = (state_q == S_DONE) && err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.bus_byte = bus_byte_c;
endmodule
